ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/muldiv_step.sv | 51 +++++
 rtl/ex_muldiv.sv | 194 +++++++++++++++++++
 tb/tb_ex_muldiv.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the EX-stage multiply/divide unit.
// Holds the muldiv FSM state encoding, the RV32M funct7 marker, the funct3
// op codes and the number of radix-2 steps per operation.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  localparam logic [2:0] F3_MUL  = 3'b000;
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam int         STEP_COUNT = 32;
  localparam logic [4:0] LAST_STEP  = 5'(STEP_COUNT - 1);

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 step of the iterative multiplier /
// divider. Build option MULDIV_DIV_EN adds the restoring-divide path and the
// div_i select port; without it only the shift-add multiply step exists.
// Ports:
//   div_i    select divide step (only with MULDIV_DIV_EN)
//   a_i/a_o  multiply: partial product      divide: partial remainder
//   b_i/b_o  multiply: multiplicand (<<1)   divide: divisor (held)
//   c_i/c_o  multiply: multiplier (>>1)     divide: dividend in / quotient out
module muldiv_step (
`ifdef MULDIV_DIV_EN
  input  logic        div_i,
`endif
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o
);

`ifdef MULDIV_DIV_EN
  logic [32:0] rem_shift;
  logic [32:0] rem_diff;

  // The partial remainder stays below the divisor, so bit 32 of the
  // difference is set exactly when the trial subtraction borrows.
  always_comb begin
    rem_shift = {a_i, c_i[31]};
    rem_diff  = rem_shift - {1'b0, b_i};
  end
`endif

  always_comb begin
    a_o = a_i + (c_i[0] ? b_i : 32'd0);
    b_o = b_i << 1;
    c_o = c_i >> 1;
`ifdef MULDIV_DIV_EN
    if (div_i) begin
      b_o = b_i;
      if (!rem_diff[32]) begin
        a_o = rem_diff[31:0];
        c_o = {c_i[30:0], 1'b1};
      end else begin
        a_o = rem_shift[31:0];
        c_o = {c_i[30:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit in the EX stage.
// Build option: define MULDIV_DIV_EN to implement DIV/DIVU/REM/REMU; when
// undefined only MUL is legal and funct3 1xx pulses illegal_o.
// Ports:
//   clk_i, start_i (async active-low reset)
//   valid_i, flush_i, funct_7_3_i, RS1data_i, RS2data_i, RDaddr_i  from ID/EX
//   stall_o    holds PC, IF/ID and ID/EX while an op is accepted or running
//   done_o     one-cycle result strobe with result_o / RDaddr_o
//   illegal_o  one-cycle strobe for an unsupported M op
//
// state | meaning
// IDLE  | ready; a legal M op is accepted on the next edge
// BUSY  | one radix-2 step per cycle, counter 0..31
// DONE  | done_o high, result_o/RDaddr_o valid; no acceptance
module ex_muldiv
  import cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        start_i,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic [9:0]  funct_7_3_i,
  input  logic [31:0] RS1data_i,
  input  logic [31:0] RS2data_i,
  input  logic [4:0]  RDaddr_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [4:0]  RDaddr_o,
  output logic        illegal_o
);

  muldiv_state_e state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [4:0]  rd_q, rd_d, rd_out_q, rd_out_d;
  logic [31:0] result_q, result_d;
  logic [31:0] step_a, step_b, step_c, fin_res;
  logic        m_type, legal, idle, accept;

`ifdef MULDIV_DIV_EN
  logic        div_q, div_d, rem_q, rem_d;
  logic        negq_q, negq_d, negr_q, negr_d;
  logic        op_signed, s1, s2;
  logic [31:0] mag1, mag2;

  always_comb begin
    op_signed = (funct_7_3_i[2:0] == F3_DIV) || (funct_7_3_i[2:0] == F3_REM);
    s1        = op_signed && RS1data_i[31];
    s2        = op_signed && RS2data_i[31];
    mag1      = s1 ? -RS1data_i : RS1data_i;
    mag2      = s2 ? -RS2data_i : RS2data_i;
  end

  assign legal = funct_7_3_i[2:0] inside {F3_MUL, F3_DIV, F3_DIVU, F3_REM, F3_REMU};
`else
  assign legal = (funct_7_3_i[2:0] == F3_MUL);
`endif

  assign m_type = valid_i && (funct_7_3_i[9:3] == FUNCT7_MEXT);
  assign idle   = (state_q == ST_IDLE);
  assign accept = idle && m_type && legal && !flush_i;

  muldiv_step u_step (
`ifdef MULDIV_DIV_EN
    .div_i (div_q),
`endif
    .a_i   (a_q),
    .b_i   (b_q),
    .c_i   (c_q),
    .a_o   (step_a),
    .b_o   (step_b),
    .c_o   (step_c)
  );

  // Sign fix-up on the magnitudes. A zero divisor never negates the quotient,
  // so it stays all-ones; the remainder then reproduces RS1 exactly.
  always_comb begin
    fin_res = a_q;
`ifdef MULDIV_DIV_EN
    if (div_q) begin
      if (rem_q) fin_res = negr_q ? -a_q : a_q;
      else       fin_res = negq_q ? -c_q : c_q;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    result_d = result_q;
`ifdef MULDIV_DIV_EN
    div_d    = div_q;
    rem_d    = rem_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_BUSY;
          cnt_d   = '0;
          a_d     = '0;
          b_d     = RS1data_i;
          c_d     = RS2data_i;
          rd_d    = RDaddr_i;
`ifdef MULDIV_DIV_EN
          div_d   = funct_7_3_i[2];
          rem_d   = funct_7_3_i[1];
          negq_d  = (s1 ^ s2) && (RS2data_i != '0);
          negr_d  = s1;
          if (funct_7_3_i[2]) begin
            b_d = mag2;
            c_d = mag1;
          end
`endif
        end
      end
      ST_BUSY: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          a_d   = step_a;
          b_d   = step_b;
          c_d   = step_c;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == LAST_STEP) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!flush_i) begin
          result_d = fin_res;
          rd_out_d = rd_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      result_q <= result_d;
    end
  end

`ifdef MULDIV_DIV_EN
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      div_q  <= 1'b0;
      rem_q  <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      rem_q  <= rem_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end
`endif

  // The result is presented combinationally during DONE so a flush in that
  // cycle leaves the previously held result untouched.
  assign done_o    = (state_q == ST_DONE) && !flush_i;
  assign result_o  = done_o ? fin_res : result_q;
  assign RDaddr_o  = done_o ? rd_q : rd_out_q;
  // Gated by start_i so every output reads 0 while reset is held.
  assign stall_o   = start_i && !flush_i &&
                     ((idle && m_type && legal) || (state_q == ST_BUSY));
  assign illegal_o = start_i && !flush_i && idle && m_type && !legal;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

  logic        clk_i = 1'b0;
  logic        start_i, valid_i, flush_i;
  logic [9:0]  funct_7_3_i;
  logic [31:0] RS1data_i, RS2data_i;
  logic [4:0]  RDaddr_i;
  logic        stall_o, done_o, illegal_o;
  logic [31:0] result_o;
  logic [4:0]  RDaddr_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  ex_muldiv dut (
    .clk_i       (clk_i),
    .start_i     (start_i),
    .valid_i     (valid_i),
    .flush_i     (flush_i),
    .funct_7_3_i (funct_7_3_i),
    .RS1data_i   (RS1data_i),
    .RS2data_i   (RS2data_i),
    .RDaddr_i    (RDaddr_i),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .result_o    (result_o),
    .RDaddr_o    (RDaddr_o),
    .illegal_o   (illegal_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_m(input logic [9:0] f);
    return f[9:3] == 7'b0000001;
  endfunction

  function automatic bit is_legal(input logic [9:0] f);
    return is_m(f) && (f[2:0] == 3'b000 || (DIV_EN && f[2]));
  endfunction

  function automatic logic [31:0] golden(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    p = {32'd0, a} * {32'd0, b};
    case (f3)
      3'b100: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
        else r = $signed(a) / $signed(b);
      end
      3'b101: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: begin
        if (b == 0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
        else r = $signed(a) % $signed(b);
      end
      3'b111: r = (b == 0) ? a : a % b;
      default: r = p[31:0];
    endcase
    return r;
  endfunction

  // Latency model: an accepted op occupies 32 busy cycles, then one done cycle.
  int          m_left    = 0;
  bit          m_done    = 1'b0;
  logic [31:0] m_res     = '0;
  logic [31:0] m_out_res = '0;
  logic [4:0]  m_rd      = '0;
  logic [4:0]  m_out_rd  = '0;

  always @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      m_left <= 0; m_done <= 1'b0; m_res <= '0; m_out_res <= '0; m_rd <= '0; m_out_rd <= '0;
    end else if (flush_i) begin
      m_left <= 0; m_done <= 1'b0;
    end else if (m_done) begin
      m_out_res <= m_res; m_out_rd <= m_rd; m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
    end else if (valid_i && is_legal(funct_7_3_i)) begin
      m_left <= 32;
      m_res  <= golden(funct_7_3_i[2:0], RS1data_i, RS2data_i);
      m_rd   <= RDaddr_i;
    end
  end

  always @(negedge clk_i) begin
    bit m_idle, e_done, e_stall, e_ill;
    m_idle  = (m_left == 0) && !m_done;
    e_done  = start_i && m_done && !flush_i;
    e_stall = start_i && !flush_i && ((m_idle && valid_i && is_legal(funct_7_3_i)) || m_left > 0);
    e_ill   = start_i && !flush_i && m_idle && valid_i && is_m(funct_7_3_i) && !is_legal(funct_7_3_i);
    check("model stall_o",   stall_o,   e_stall);
    check("model done_o",    done_o,    e_done);
    check("model illegal_o", illegal_o, e_ill);
    check("model result_o",  result_o,  e_done ? m_res : m_out_res);
    check("model RDaddr_o",  RDaddr_o,  e_done ? m_rd : m_out_rd);
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    funct_7_3_i = {7'b0000001, f3};
    RS1data_i   = a;
    RS2data_i   = b;
    RDaddr_i    = rd;
    valid_i     = 1'b1;
  endtask

  // Called #1 after a rising edge with the unit idle.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input string name);
    int acc_cyc, nstall;
    bit seen;
    drive(f3, a, b, rd);
    @(negedge clk_i);
    acc_cyc = cyc;
    nstall  = stall_o ? 1 : 0;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        seen = 1'b1;
        check({name, " latency"}, cyc - acc_cyc, 33);
        check({name, " result"}, result_o, exp);
        check({name, " rd"}, RDaddr_o, rd);
      end else if (stall_o) begin
        nstall++;
      end
    end
    check({name, " done seen"}, seen, 1);
    check({name, " stall cycles"}, nstall, 33);
    @(posedge clk_i); #1;
  endtask

  task automatic illegal_op(input logic [2:0] f3, input string name);
    drive(f3, 32'd12, 32'd3, 5'd9);
    @(negedge clk_i);
    check({name, " illegal pulse"}, illegal_o, 1);
    check({name, " no stall"}, stall_o, 0);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    @(negedge clk_i);
    check({name, " illegal drops"}, illegal_o, 0);
    check({name, " stays idle"}, stall_o, 0);
    @(posedge clk_i); #1;
  endtask

  task automatic count_done(input int ncyc, output int ndone);
    ndone = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk_i);
      if (done_o) ndone++;
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    int ndone, c1, c2;
    bit seen;
    start_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
    funct_7_3_i = '0; RS1data_i = '0; RS2data_i = '0; RDaddr_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset stall_o",   stall_o,   0);
    check("reset done_o",    done_o,    0);
    check("reset illegal_o", illegal_o, 0);
    check("reset result_o",  result_o,  0);
    check("reset RDaddr_o",  RDaddr_o,  0);
    start_i = 1'b1;
    @(posedge clk_i); #1;

    run_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd3, 32'hFFFFFFEB, "mul 7*-3");
    run_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'h00000001, "mul -1*-1");
    run_op(3'b000, 32'h12345678, 32'h00000010, 5'd31, 32'h23456780, "mul x16");

`ifdef MULDIV_DIV_EN
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, "div -7/2");
    run_op(3'b110, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, "rem -7/2");
    run_op(3'b101, 32'hFFFFFFFE, 32'd2, 5'd7, 32'h7FFFFFFF, "divu big/2");
    run_op(3'b100, 32'd5, 32'd0, 5'd8, 32'hFFFFFFFF, "div 5/0");
    run_op(3'b110, 32'd5, 32'd0, 5'd9, 32'd5, "rem 5/0");
    run_op(3'b100, 32'hFFFFFFF9, 32'd0, 5'd10, 32'hFFFFFFFF, "div -7/0");
    run_op(3'b110, 32'hFFFFFFF9, 32'd0, 5'd11, 32'hFFFFFFF9, "rem -7/0");
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, "div ovf");
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0, "rem ovf");
    run_op(3'b111, 32'd100, 32'd7, 5'd14, 32'd2, "remu 100/7");
`else
    illegal_op(3'b100, "div without divider");
`endif
    illegal_op(3'b001, "funct3 001");

    // Flush at BUSY step 10.
    drive(3'b000, 32'd3, 32'd4, 5'd15);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(negedge clk_i);
    check("flush busy stall", stall_o, 0);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    check("after flush stall", stall_o, 0);
    count_done(40, ndone);
    check("flush busy no done", ndone, 0);

    // Flush in IDLE blocks acceptance.
    drive(3'b000, 32'd5, 32'd6, 5'd16);
    flush_i = 1'b1;
    @(negedge clk_i);
    check("flush idle stall", stall_o, 0);
    @(posedge clk_i); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    count_done(40, ndone);
    check("flush idle no done", ndone, 0);

    // Reset at BUSY step 20, then immediate reuse.
    drive(3'b000, 32'd6, 32'd7, 5'd17);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (20) @(posedge clk_i);
    #1;
    start_i = 1'b0;
    #1;
    check("midreset stall_o",   stall_o,   0);
    check("midreset done_o",    done_o,    0);
    check("midreset illegal_o", illegal_o, 0);
    check("midreset result_o",  result_o,  0);
    check("midreset RDaddr_o",  RDaddr_o,  0);
    @(posedge clk_i); #1;
    start_i = 1'b1;
    run_op(3'b000, 32'd6, 32'd7, 5'd18, 32'd42, "mul after reset");

    // Back-to-back with valid_i held across the first op.
    drive(3'b000, 32'd9, 32'd9, 5'd19);
    @(posedge clk_i); #1;
`ifdef MULDIV_DIV_EN
    drive(3'b100, 32'd100, 32'd7, 5'd20);
`else
    drive(3'b000, 32'd5, 32'd5, 5'd20);
`endif
    seen = 1'b0; c1 = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        seen = 1'b1; c1 = cyc;
        check("b2b first result", result_o, 32'd81);
      end
    end
    check("b2b first done seen", seen, 1);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    seen = 1'b0; c2 = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        seen = 1'b1; c2 = cyc;
        check("b2b second result", result_o, DIV_EN ? 32'd14 : 32'd25);
        check("b2b spacing", c2 - c1, 34);
      end
    end
    check("b2b second done seen", seen, 1);
    repeat (3) @(posedge clk_i);
    #1;
    check("held result", result_o, DIV_EN ? 32'd14 : 32'd25);
    check("held rd", RDaddr_o, 5'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
